tx_burst_scheduler: RTL
=======================

// Module: tx_burst_scheduler
// PURPOSE
//   Sequences the DCSK transmitter (tx) on behalf of N_REQ message sources.
//   Round-robin arbitrates queued 32-bit words, drives the tx seed-load/send
//   handshake, tracks o_is_sending to detect message completion, and inserts
//   guard silence between bursts so the receiver (Demod_Top) sees framed bursts.
// PARAMETERS
//   N_REQ          2    number of requesters (>=1)
//   SEED_W         32   width of PRBS seed passed to tx
//   SF_W           2    spreading-factor code width (0=SF2,1=SF4,2=SF8,3=SF16)
//   START_TIMEOUT  8    cycles after o_send to wait for i_is_sending rise (>=1)
//   GAP_CYCLES     4    guard silence after a burst, in cycles (>=1)
//   MAX_BURST      4    max back-to-back messages before a forced gap (>=1)
// PORTS
//   i_clk          in   1            system clock
//   i_arst_n       in   1            asynchronous reset, active low
//   i_seed         in   SEED_W       seed value, sampled in SEED state
//   i_reseed       in   1            request seed reload (pulse; latched pending)
//   i_req          in   N_REQ        per-source message valid (hold until grant)
//   i_msg          in   N_REQ*32     per-source message, source k at [32k+:32]
//   i_sf           in   N_REQ*SF_W   per-source spreading factor
//   o_grant        out  N_REQ        one-hot, 1-cycle pulse: message consumed
//   o_seed         out  SEED_W       to tx i_seed
//   o_load_seed    out  1            to tx i_load_seed (1-cycle pulse)
//   o_send         out  1            to tx i_send (1-cycle pulse)
//   o_msg          out  32           to tx i_msg
//   o_sf           out  SF_W         to tx i_sf
//   i_is_sending   in   1            from tx o_is_sending
//   o_busy         out  1            state != IDLE
//   o_timeout_err  out  1            sticky: tx failed to start
//   i_err_clr      in   1            clears o_timeout_err
//   o_msg_count    out  16           messages completed, wraps at 2^16
// BEHAVIOUR
//   Reset (async, i_arst_n=0): all outputs 0, rr pointer=N_REQ-1, burst_cnt=0,
//     reseed_pend=0, state=SEED. Applies immediately, also mid-message.
//   All outputs registered. States: SEED, IDLE, SEND, WAIT_START, WAIT_DONE, GAP.
//   SEED: o_seed<=i_seed, o_load_seed=1 for exactly 1 cycle, clear reseed_pend,
//     -> IDLE. No send occurs after reset before one SEED cycle.
//   i_reseed sets reseed_pend in any state; served only from IDLE.
//   IDLE: reseed_pend has priority -> SEED. Else if |i_req: winner = first set
//     bit searching from rr+1 with wrap; next cycle (SEND) o_grant[winner]=1,
//     o_send=1, o_msg/o_sf = winner's inputs; rr<=winner. No req: burst_cnt<=0.
//   SEND (1 cycle) -> WAIT_START, timer<=0. o_msg/o_sf held stable from SEND
//     until exit of WAIT_DONE/GAP entry.
//   WAIT_START: i_is_sending=1 -> WAIT_DONE. timer reaches START_TIMEOUT with
//     no rise -> o_timeout_err<=1, msg dropped (not counted), -> GAP.
//   WAIT_DONE: i_is_sending=0 -> o_msg_count++, burst_cnt++; if new
//     burst_cnt==MAX_BURST -> GAP (burst_cnt<=0) else -> IDLE (back-to-back).
//   GAP: exactly GAP_CYCLES cycles, o_send=0, then -> IDLE.
//   Request->o_send latency: 1 cycle from IDLE; requests arriving elsewhere wait.
//   o_timeout_err: set and i_err_clr same cycle -> set wins.
//   Single requester: rr search degenerates to fixed grant; no starvation with
//     N_REQ>1 (any held req granted within N_REQ grants).
// TESTING
//   1. Release reset, i_seed=32'hA5A5_1234 -> o_load_seed high 1 cycle,
//      o_seed=A5A5_1234, then o_busy=0, no o_send.
//   2. i_req=2'b01, msg 32'hDEAD_BEEF, sf=2; mock tx raises is_sending 2 cycles
//      after o_send for 64 cycles -> grant[0]+o_send same cycle, o_msg/o_sf
//      stable throughout, o_msg_count=1, next send only after IDLE.
//   3. Both requesters held high -> grants 0,1,0,1 then GAP of 4 cycles
//      (o_send low), then grant 0; pair with real tx+Demod_Top: all words match.
//   4. Mock tx never asserts is_sending -> o_timeout_err=1 exactly 8 cycles
//      after o_send, count unchanged; i_err_clr pulse -> 0.
//   5. i_reseed pulse during WAIT_DONE with req pending -> no load until done;
//      then o_load_seed pulse precedes the next grant.
//   6. Assert i_arst_n=0 in WAIT_DONE -> all outputs 0 same cycle; on release
//      SEED pulse, o_msg_count=0, pending request then granted normally.

Source files
------------

// File: rtl/tx_burst_scheduler.sv
// Burst scheduler for the DCSK transmitter: round-robin arbitration of queued
// words, seed-load/send handshake with the tx, completion tracking and guard gaps.
module tx_burst_scheduler #(
    parameter int N_REQ         = 2,
    parameter int SEED_W        = 32,
    parameter int SF_W          = 2,
    parameter int START_TIMEOUT = 8,
    parameter int GAP_CYCLES    = 4,
    parameter int MAX_BURST     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic [SEED_W-1:0]      i_seed,
    input  logic                   i_reseed,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*32-1:0]    i_msg,
    input  logic [N_REQ*SF_W-1:0]  i_sf,
    output logic [N_REQ-1:0]       o_grant,
    output logic [SEED_W-1:0]      o_seed,
    output logic                   o_load_seed,
    output logic                   o_send,
    output logic [31:0]            o_msg,
    output logic [SF_W-1:0]        o_sf,
    input  logic                   i_is_sending,
    output logic                   o_busy,
    output logic                   o_timeout_err,
    input  logic                   i_err_clr,
    output logic [15:0]            o_msg_count
);

    localparam int RR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W   = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [RR_W-1:0]    RR_LAST   = RR_W'(N_REQ - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(START_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic [2:0] {
        S_SEED,
        S_IDLE,
        S_SEND,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state, state_d;
    logic [TMR_W-1:0]   timer, timer_d;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    logic [BURST_W-1:0] burst_cnt, burst_d, burst_inc;
    logic [RR_W-1:0]    rr, rr_d;
    logic               reseed_pend, pend_d;

    logic [N_REQ-1:0]   grant_d;
    logic [SEED_W-1:0]  seed_d;
    logic               load_d, send_d, busy_d, err_d, err_set;
    logic [31:0]        msg_d, sel_msg;
    logic [SF_W-1:0]    sf_d, sel_sf;
    logic [15:0]        count_d;

    logic [RR_W-1:0]    cand, winner;
    logic               found;

    // Round-robin search starts one past the last winner and wraps.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        cand    = rr;
        winner  = rr;
        found   = 1'b0;
        sel_msg = '0;
        sel_sf  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == RR_LAST) ? '0 : cand + 1'b1;
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == RR_W'(k)) begin
                sel_msg = i_msg[32*k +: 32];
                sel_sf  = i_sf[SF_W*k +: SF_W];
            end
        end
    end

    always_comb begin
        state_d   = state;
        timer_d   = timer;
        gap_d     = gap_cnt;
        burst_d   = burst_cnt;
        burst_inc = burst_cnt + 1'b1;
        rr_d      = rr;
        pend_d    = reseed_pend;
        grant_d   = '0;
        send_d    = 1'b0;
        load_d    = 1'b0;
        seed_d    = o_seed;
        msg_d     = o_msg;
        sf_d      = o_sf;
        count_d   = o_msg_count;
        err_set   = 1'b0;

        unique case (state)
            S_SEED: begin
                seed_d  = i_seed;
                load_d  = 1'b1;
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (reseed_pend) begin
                    state_d = S_SEED;
                end else if (found) begin
                    state_d         = S_SEND;
                    grant_d[winner] = 1'b1;
                    send_d          = 1'b1;
                    msg_d           = sel_msg;
                    sf_d            = sel_sf;
                    rr_d            = winner;
                end else begin
                    burst_d = '0;
                end
            end
            S_SEND: begin
                // The send cycle itself counts toward the start timeout.
                state_d = S_WAIT_START;
                timer_d = TMR_W'(1);
            end
            S_WAIT_START: begin
                if (i_is_sending) begin
                    state_d = S_WAIT_DONE;
                end else if (timer >= TMR_LAST) begin
                    err_set = 1'b1;
                    state_d = S_GAP;
                    gap_d   = '0;
                    burst_d = '0;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!i_is_sending) begin
                    count_d = o_msg_count + 16'd1;
                    if (burst_inc == BURST_MAX) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                        burst_d = '0;
                    end else begin
                        state_d = S_IDLE;
                        burst_d = burst_inc;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_d = S_IDLE;
                else                     gap_d   = gap_cnt + 1'b1;
            end
            default: state_d = S_SEED;
        endcase

        // A reseed pulse is remembered in every state, including SEED itself.
        if (i_reseed) pend_d = 1'b1;

        if (err_set)        err_d = 1'b1;
        else if (i_err_clr) err_d = 1'b0;
        else                err_d = o_timeout_err;

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state         <= S_SEED;
            timer         <= '0;
            gap_cnt       <= '0;
            burst_cnt     <= '0;
            rr            <= RR_LAST;
            reseed_pend   <= 1'b0;
            o_grant       <= '0;
            o_seed        <= '0;
            o_load_seed   <= 1'b0;
            o_send        <= 1'b0;
            o_msg         <= '0;
            o_sf          <= '0;
            o_busy        <= 1'b0;
            o_timeout_err <= 1'b0;
            o_msg_count   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state         <= state_d;
            timer         <= timer_d;
            gap_cnt       <= gap_d;
            burst_cnt     <= burst_d;
            rr            <= rr_d;
            reseed_pend   <= pend_d;
            o_grant       <= grant_d;
            o_seed        <= seed_d;
            o_load_seed   <= load_d;
            o_send        <= send_d;
            o_msg         <= msg_d;
            o_sf          <= sf_d;
            o_busy        <= busy_d;
            o_timeout_err <= err_d;
            o_msg_count   <= count_d;
        end
    end

endmodule
